// File: rtl/tpu_io_pkg.sv
// Shared definitions for the TPU UART command loader.
// Holds the host command opcodes, response codes, memory select encodings,
// the loader state enum and a saturating increment helper.
package tpu_io_pkg;

    // Host command opcodes, accepted only while the loader is idle.
    localparam logic [7:0] CMD_LOAD_A      = 8'h01;
    localparam logic [7:0] CMD_LOAD_B      = 8'h02;
    localparam logic [7:0] CMD_START       = 8'h03;
    localparam logic [7:0] CMD_READ_RESULT = 8'h04;
    localparam logic [7:0] CMD_STATUS      = 8'h05;

    // Single-byte responses returned to the host.
    localparam logic [7:0] RSP_ACK  = 8'hAA;
    localparam logic [7:0] RSP_ERR  = 8'hEE;
    localparam logic [7:0] RSP_BUSY = 8'hEB;

    // Memory select encodings.
    localparam logic [1:0] MEM_SEL_A      = 2'b00;
    localparam logic [1:0] MEM_SEL_B      = 2'b01;
    localparam logic [1:0] MEM_SEL_RESULT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_SEND,
        ST_READ_LO,
        ST_READ_HI
    } loader_state_t;

    // Increment that sticks at 0xFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/tpu_gap_timer.sv
// Inter-byte gap timer.
// Counts cycles while run is high; clear restarts the count and has priority,
// so a byte arriving in the expiry cycle still wins. expired stays high (and
// the count holds) once TIMEOUT_CYCLES cycles have elapsed without a clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero
//   run        : count this cycle
//   expired    : gap has reached TIMEOUT_CYCLES
module tpu_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    assign expired = (count == LIMIT);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tpu_uart_cmd_loader.sv
// Framed byte-level command engine between the UART and the TPU memories.
// Loads matrix A/B as little-endian 16-bit words, pulses TPU start, reports
// status and streams the result memory back one byte at a time.
//   rx_data/rx_valid : received byte strobe
//   tx_data/tx_valid/tx_ready : outgoing byte, held until accepted
//   mem_addr/mem_wdata/mem_we/mem_sel/mem_rdata : matrix memory port
//   tpu_start/tpu_busy/tpu_done : TPU controller handshake
//   loader_busy : not idle;  err_count : saturating protocol error count
module tpu_uart_cmd_loader
    import tpu_io_pkg::*;
#(
    parameter int N_ELEM         = 64,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic [1:0]        mem_sel,
    input  logic [15:0]       mem_rdata,
    output logic              tpu_start,
    input  logic              tpu_busy,
    input  logic              tpu_done,
    output logic              loader_busy,
    output logic [7:0]        err_count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

    loader_state_t state;
    logic [7:0]    lo_byte;
    logic          in_load;
    logic          gap_expired;

    assign in_load     = (state == ST_LOAD_LO) || (state == ST_LOAD_HI);
    assign loader_busy = (state != ST_IDLE);

    tpu_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_valid || !in_load),
        .run     (in_load),
        .expired (gap_expired)
    );

    // mem_addr doubles as the word index: it is held during the write strobe
    // and advanced in the following LOAD_LO cycle, so the last word never
    // increments past N_ELEM-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lo_byte   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= MEM_SEL_A;
            tpu_start <= 1'b0;
            err_count <= '0;
        end else begin
            mem_we    <= 1'b0;
            tpu_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_LOAD_A, CMD_LOAD_B: begin
                                mem_sel  <= (rx_data == CMD_LOAD_A) ? MEM_SEL_A : MEM_SEL_B;
                                mem_addr <= '0;
                                state    <= ST_LOAD_LO;
                            end
                            CMD_START: begin
                                tpu_start <= !tpu_busy;
                                tx_data   <= tpu_busy ? RSP_BUSY : RSP_ACK;
                                tx_valid  <= 1'b1;
                                state     <= ST_SEND;
                            end
                            CMD_READ_RESULT: begin
                                if (tpu_busy) begin
                                    tx_data  <= RSP_BUSY;
                                    tx_valid <= 1'b1;
                                    state    <= ST_SEND;
                                end else begin
                                    mem_sel  <= MEM_SEL_RESULT;
                                    mem_addr <= '0;
                                    state    <= ST_READ_LO;
                                end
                            end
                            CMD_STATUS: begin
                                tx_data  <= {6'b0, tpu_done, tpu_busy};
                                tx_valid <= 1'b1;
                                state    <= ST_SEND;
                            end
                            default: begin
                                tx_data   <= RSP_ERR;
                                tx_valid  <= 1'b1;
                                err_count <= sat_inc8(err_count);
                                state     <= ST_SEND;
                            end
                        endcase
                    end
                end
                ST_LOAD_LO: begin
                    if (mem_we) mem_addr <= mem_addr + 1'b1;
                    if (rx_valid) begin
                        lo_byte <= rx_data;
                        state   <= ST_LOAD_HI;
                    end else if (gap_expired) begin
                        tx_data   <= RSP_ERR;
                        tx_valid  <= 1'b1;
                        err_count <= sat_inc8(err_count);
                        state     <= ST_SEND;
                    end
                end
                ST_LOAD_HI: begin
                    if (rx_valid) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {rx_data, lo_byte};
                        if (mem_addr == LAST_ADDR) begin
                            tx_data  <= RSP_ACK;
                            tx_valid <= 1'b1;
                            state    <= ST_SEND;
                        end else begin
                            state <= ST_LOAD_LO;
                        end
                    end else if (gap_expired) begin
                        tx_data   <= RSP_ERR;
                        tx_valid  <= 1'b1;
                        err_count <= sat_inc8(err_count);
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rx_valid) err_count <= sat_inc8(err_count);
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_READ_LO: begin
                    if (rx_valid) err_count <= sat_inc8(err_count);
                    if (!tx_valid) begin
                        tx_data  <= mem_rdata[7:0];
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_READ_HI;
                    end
                end
                ST_READ_HI: begin
                    if (rx_valid) err_count <= sat_inc8(err_count);
                    if (!tx_valid) begin
                        tx_data  <= mem_rdata[15:8];
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (mem_addr == LAST_ADDR) begin
                            state <= ST_IDLE;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            state    <= ST_READ_LO;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_uart_cmd_loader.sv
// Directed self-checking bench for tpu_uart_cmd_loader (timeout shortened to 100).
module tb_tpu_uart_cmd_loader;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [15:0] mem_rdata;
    logic        tpu_start;
    logic        tpu_busy;
    logic        tpu_done;
    logic        loader_busy;
    logic [7:0]  err_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [1:0]  sel;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int         start_cnt   = 0;
    int         stable_errs = 0;
    int         ready_mode  = 0;  // 0: always ready, 1: ready 1-in-3, 2: never
    int         cyc         = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    always #5 clk = ~clk;

    // Result memory model: word i holds 0x1200+i.
    assign mem_rdata = (mem_sel == 2'b10) ? (16'h1200 + 16'(mem_addr)) : 16'h0000;

    tpu_uart_cmd_loader #(.N_ELEM(64), .ADDR_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .tpu_start(tpu_start),
        .tpu_busy(tpu_busy), .tpu_done(tpu_done), .loader_busy(loader_busy),
        .err_count(err_count)
    );

    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            1:       tx_ready = (cyc % 3 == 0);
            2:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    // Observe at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) wr_q.push_back('{sel: mem_sel, addr: mem_addr, data: mem_wdata});
            if (tpu_start) start_cnt++;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stable_errs++;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_obs();
        wr_q.delete();
        tx_q.delete();
        start_cnt   = 0;
        stable_errs = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Waits for one transmitted byte; ok=0 if the budget runs out.
    task automatic wait_tx(input int budget, output logic [7:0] b, output bit ok);
        int n = 0;
        while (tx_q.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        ok = (tx_q.size() != 0);
        b  = ok ? tx_q.pop_front() : 8'hxx;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_sel, tpu_start} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: tx_data=%h tx_valid=%b addr=%h wdata=%h we=%b sel=%b start=%b, want all 0",
                     tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_sel, tpu_start);
        end
        tests_run++;
        if (loader_busy !== 1'b0 || err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_status: busy=%b err=%h, want 0/00", loader_busy, err_count);
        end
    endtask

    task automatic test_load_a();
        logic [7:0] b;
        bit ok;
        clear_obs();
        send_byte(8'h01);
        for (int k = 0; k < 64; k++) begin
            send_byte(8'(k));
            send_byte(8'h3C);
        end
        wait_tx(50, b, ok);
        tests_run++;
        if (wr_q.size() != 64) begin
            tests_failed++;
            $display("FAIL load_a_count: got %0d writes, want 64", wr_q.size());
        end
        for (int k = 0; k < 64 && k < wr_q.size(); k++) begin
            tests_run++;
            if (wr_q[k].sel !== 2'b00 || wr_q[k].addr !== 8'(k) || wr_q[k].data !== 16'h3C00 + 16'(k)) begin
                tests_failed++;
                $display("FAIL load_a_write[%0d]: sel=%b addr=%h data=%h, want 00/%h/%h",
                         k, wr_q[k].sel, wr_q[k].addr, wr_q[k].data, 8'(k), 16'h3C00 + 16'(k));
            end
        end
        tests_run++;
        if (!ok || b !== 8'hAA) begin
            tests_failed++;
            $display("FAIL load_a_ack: got %h (seen=%0d), want aa", b, ok);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (loader_busy !== 1'b0 || tx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL load_a_idle: busy=%b extra_tx=%0d, want 0/0", loader_busy, tx_q.size());
        end
    endtask

    task automatic test_start();
        logic [7:0] b;
        bit ok;
        clear_obs();
        tpu_busy = 1'b0;
        send_byte(8'h03);
        wait_tx(50, b, ok);
        tests_run++;
        if (start_cnt != 1 || !ok || b !== 8'hAA) begin
            tests_failed++;
            $display("FAIL start_idle: pulses=%0d rsp=%h, want 1/aa", start_cnt, b);
        end
        clear_obs();
        tpu_busy = 1'b1;
        send_byte(8'h03);
        wait_tx(50, b, ok);
        tests_run++;
        if (start_cnt != 0 || !ok || b !== 8'hEB) begin
            tests_failed++;
            $display("FAIL start_busy: pulses=%0d rsp=%h, want 0/eb", start_cnt, b);
        end
        tpu_busy = 1'b0;
    endtask

    task automatic test_read();
        logic [7:0] exp;
        int n = 0;
        clear_obs();
        ready_mode = 1;
        send_byte(8'h04);
        while (tx_q.size() < 128 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        ready_mode = 0;
        tests_run++;
        if (tx_q.size() != 128) begin
            tests_failed++;
            $display("FAIL read_count: got %0d bytes, want 128", tx_q.size());
        end
        for (int j = 0; j < 128 && j < tx_q.size(); j++) begin
            exp = (j % 2 == 0) ? 8'(j / 2) : 8'h12;
            tests_run++;
            if (tx_q[j] !== exp) begin
                tests_failed++;
                $display("FAIL read_byte[%0d]: got %h, want %h", j, tx_q[j], exp);
            end
        end
        tests_run++;
        if (stable_errs != 0 || loader_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_stall: unstable=%0d busy=%b, want 0/0", stable_errs, loader_busy);
        end
    endtask

    task automatic test_rx_in_send();
        logic [7:0] b;
        bit ok;
        clear_obs();
        tpu_busy   = 1'b0;
        tpu_done   = 1'b0;
        ready_mode = 2;
        send_byte(8'h05);
        @(negedge clk);
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL send_hold: valid=%b data=%h, want 1/00", tx_valid, tx_data);
        end
        send_byte(8'h55);
        @(negedge clk);
        tests_run++;
        if (err_count !== 8'h01 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL send_drop: err=%h writes=%0d, want 01/0", err_count, wr_q.size());
        end
        ready_mode = 0;
        wait_tx(20, b, ok);
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok || b !== 8'h00 || loader_busy !== 1'b0 || stable_errs != 0) begin
            tests_failed++;
            $display("FAIL send_release: rsp=%h busy=%b unstable=%0d, want 00/0/0", b, loader_busy, stable_errs);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        bit ok;
        do_reset();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        wait_tx(TMO + 50, b, ok);
        tests_run++;
        if (wr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL timeout_writes: got %0d, want 2", wr_q.size());
        end else begin
            tests_run++;
            if (wr_q[0] !== '{2'b00, 8'h00, 16'h2211} || wr_q[1] !== '{2'b00, 8'h01, 16'h4433}) begin
                tests_failed++;
                $display("FAIL timeout_data: w0=%h w1=%h, want 0002211/0014433", wr_q[0], wr_q[1]);
            end
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (!ok || b !== 8'hEE || err_count !== 8'h01 || loader_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: rsp=%h err=%h busy=%b, want ee/01/0", b, err_count, loader_busy);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] b;
        bit ok;
        do_reset();
        tpu_done = 1'b1;
        tpu_busy = 1'b0;
        send_byte(8'h7F);
        wait_tx(20, b, ok);
        tests_run++;
        if (!ok || b !== 8'hEE) begin
            tests_failed++;
            $display("FAIL bad_cmd_rsp: got %h, want ee", b);
        end
        send_byte(8'h05);
        wait_tx(20, b, ok);
        tests_run++;
        if (!ok || b !== 8'h02 || err_count !== 8'h01) begin
            tests_failed++;
            $display("FAIL bad_cmd_status: rsp=%h err=%h, want 02/01", b, err_count);
        end
        tpu_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        bit ok;
        do_reset();
        send_byte(8'h02);
        for (int k = 0; k < 10; k++) send_byte(8'h80 + 8'(k));
        tests_run++;
        if (wr_q.size() != 5 || mem_sel !== 2'b01 || loader_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_load_b: writes=%0d sel=%b busy=%b, want 5/01/1", wr_q.size(), mem_sel, loader_busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({tx_data, tx_valid, mem_addr, mem_wdata, mem_we, mem_sel, tpu_start, loader_busy, err_count} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: addr=%h wdata=%h sel=%b busy=%b err=%h, want all 0",
                     mem_addr, mem_wdata, mem_sel, loader_busy, err_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_obs();
        tpu_busy = 1'b1;
        send_byte(8'h05);
        wait_tx(20, b, ok);
        tests_run++;
        if (!ok || b !== 8'h01 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL post_reset_status: rsp=%h writes=%0d, want 01/0", b, wr_q.size());
        end
        tpu_busy = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tpu_busy = 1'b0;
        tpu_done = 1'b0;
        test_reset();
        test_load_a();
        test_start();
        test_read();
        test_rx_in_send();
        test_timeout();
        test_bad_cmd();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
